// File: rtl/temp_bcd_conv.sv
// ADT7420 raw temperature to sign + BCD digits via a 9-cycle double dabble; done 11 edges after start.
// Optional macro TEMP_FRAC_TENTHS_EN adds a tenths digit; without it tenths is the 4'hF blank code.
module temp_bcd_conv (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dis_data,
  output logic        busy,
  output logic        done,
  output logic        sign,
  output logic [3:0]  huns,
  output logic [3:0]  tens,
  output logic [3:0]  ones,
  output logic [3:0]  tenths
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_busy;
  logic [12:0] r_raw;
  logic        r_neg;
  logic [8:0]  r_bin;
  logic [11:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_done;
  logic        r_sign;
  logic [3:0]  r_huns;
  logic [3:0]  r_tens;
  logic [3:0]  r_ones;
  logic [13:0] w_mag;
  logic [11:0] w_adj;

  // Absolute value of the 13-bit reading; -4096 needs the extra bit to become +4096.
  assign w_mag = r_raw[12] ? (14'd0 - {r_raw[12], r_raw}) : {1'b0, r_raw};

  assign w_adj[3:0]  = (r_bcd[3:0]  >= 4'd5) ? r_bcd[3:0]  + 4'd3 : r_bcd[3:0];
  assign w_adj[7:4]  = (r_bcd[7:4]  >= 4'd5) ? r_bcd[7:4]  + 4'd3 : r_bcd[7:4];
  assign w_adj[11:8] = (r_bcd[11:8] >= 4'd5) ? r_bcd[11:8] + 4'd3 : r_bcd[11:8];

`ifdef TEMP_FRAC_TENTHS_EN
  logic [3:0] r_frac;
  logic [3:0] r_tenths;
  logic [7:0] w_frac_x10;
  logic       w_unused;

  assign w_frac_x10 = {1'b0, r_frac, 3'b000} + {3'b000, r_frac, 1'b0};
  assign tenths     = r_tenths;
  assign w_unused   = &{1'b0, dis_data[2:0], w_mag[13]};
`else
  logic w_unused;

  assign tenths   = 4'hF;
  assign w_unused = &{1'b0, dis_data[2:0], w_mag[13], w_mag[3:0]};
`endif

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_busy      = 1'b1;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        w_busy = 1'b1;
        if (r_cnt == 4'd8) w_state_nxt = FIN;
      end
      FIN: begin
        w_busy      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_raw  <= 13'd0;
      r_neg  <= 1'b0;
      r_bin  <= 9'd0;
      r_bcd  <= 12'd0;
      r_cnt  <= 4'd0;
      r_done <= 1'b0;
      r_sign <= 1'b0;
      r_huns <= 4'd0;
      r_tens <= 4'd0;
      r_ones <= 4'd0;
`ifdef TEMP_FRAC_TENTHS_EN
      r_frac   <= 4'd0;
      r_tenths <= 4'd0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) r_raw <= dis_data[15:3];
        end
        LOAD: begin
          r_neg <= r_raw[12];
          r_bin <= w_mag[12:4];
          r_bcd <= 12'd0;
          r_cnt <= 4'd0;
`ifdef TEMP_FRAC_TENTHS_EN
          r_frac <= w_mag[3:0];
`endif
        end
        SHIFT: begin
          r_bcd <= {w_adj[10:0], r_bin[8]};
          r_bin <= {r_bin[7:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
        end
        FIN: begin
          // All visible results change on this one edge so no partial value is ever seen.
          r_done <= 1'b1;
          r_sign <= r_neg;
          r_huns <= r_bcd[11:8];
          r_tens <= r_bcd[7:4];
          r_ones <= r_bcd[3:0];
`ifdef TEMP_FRAC_TENTHS_EN
          r_tenths <= w_frac_x10[7:4];
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign sign = r_sign;
  assign huns = r_huns;
  assign tens = r_tens;
  assign ones = r_ones;

endmodule
